// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Latency: start accepted in cycle 0 -> valid pulse in cycle BIN_W+1; one conversion per BIN_W+2 cycles.
// Backpressure: none; start is only sampled in IDLE, so requests while busy are dropped, not queued.
//
// Ports:
//   CLK100MHZ  system clock, rising edge
//   reset      asynchronous active-high reset
//   start      conversion request (sampled only when idle)
//   bin        unsigned binary input, captured on the accepting edge
//   busy       high while a conversion is in flight (SHIFT and DONE)
//   valid      one-cycle pulse, bcd/overflow/digit_en hold a fresh result this cycle
//   bcd        packed BCD result, digit i at [4i+3:4i], held between conversions
//   overflow   last result did not fit in DIGITS digits (bcd saturated to all 9s)
//   digit_en   per-digit display enable, optionally blanking leading zeros
module bcd_convert_seq #(
    parameter int BIN_W         = 16,
    parameter int DIGITS        = 5,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [DIGITS-1:0] EN_RST = (BLANK_LEADING != 0) ? DIGITS'(1) : {DIGITS{1'b1}};

    generate
        if (DIGITS < 1 || BIN_W < 1) begin : g_param_check
            $error("bcd_convert_seq: DIGITS and BIN_W must both be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [BIN_W-1:0]  shift_q;
    logic [SW-1:0]     scratch_q;
    logic              ovf_q;
    logic [CW-1:0]     cnt_q;

    // Per-step datapath
    logic [SW-1:0]     adj;
    logic [SW-1:0]     scratch_shift;
    logic [BIN_W-1:0]  shift_next;
    logic              out_bit;
    logic              last_step;
    logic              final_ovf;
    logic [SW-1:0]     result;

    // Display enable: a digit is lit if it or any more significant digit is nonzero.
    // The units digit is always lit so zero still shows as "0".
    function automatic logic [DIGITS-1:0] calc_en(input logic [SW-1:0] val);
        logic [DIGITS-1:0] en;
        logic              seen;
        en   = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen  = seen | (|val[4*i +: 4]);
            en[i] = seen;
        end
        en[0] = 1'b1;
        if (BLANK_LEADING == 0) begin
            en = {DIGITS{1'b1}};
        end
        return en;
    endfunction

    // Add-3 correction is purely per-digit, 4-bit wrapping; digits never exceed 9
    // before correction, so no carry between digits is ever needed.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        out_bit       = adj[SW-1];
        scratch_shift = {adj[SW-2:0], shift_q[BIN_W-1]};
        shift_next    = shift_q << 1;
        last_step     = (cnt_q == CW'(1));
        // A bit falling off the top of scratch means the value needs more digits.
        final_ovf     = ovf_q | out_bit;
        result        = final_ovf ? {DIGITS{4'h9}} : scratch_shift;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_SHIFT;
            S_SHIFT: if (last_step) state_d = S_DONE;
            S_DONE:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result registers load on the final shift edge so they are already stable
    // during DONE, the cycle in which valid is high.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            bcd       <= '0;
            overflow  <= 1'b0;
            digit_en  <= EN_RST;
            busy      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            busy  <= (state_d != S_IDLE);
            valid <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shift_q   <= bin;
                        scratch_q <= '0;
                        ovf_q     <= 1'b0;
                        cnt_q     <= CW'(BIN_W);
                    end
                end
                S_SHIFT: begin
                    shift_q   <= shift_next;
                    scratch_q <= scratch_shift;
                    ovf_q     <= final_ovf;
                    cnt_q     <= cnt_q - CW'(1);
                    if (last_step) begin
                        bcd      <= result;
                        overflow <= final_ovf;
                        digit_en <= calc_en(result);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq: three instances (5 digits blanking, 4 digits, 5 digits no blanking).
// Cycle k is the clock period starting at the k-th rising edge after start is first driven (cycle 0).
// Outputs are sampled 1 time unit after the rising edge.
module tb_bcd_convert_seq;

    logic clk = 1'b0;
    logic rst;

    logic        start_a, busy_a, valid_a, ovf_a;
    logic [15:0] bin_a;
    logic [19:0] bcd_a;
    logic [4:0]  den_a;

    logic        start_b, busy_b, valid_b, ovf_b;
    logic [15:0] bin_b;
    logic [15:0] bcd_b;
    logic [3:0]  den_b;

    logic        start_c, busy_c, valid_c, ovf_c;
    logic [15:0] bin_c;
    logic [19:0] bcd_c;
    logic [4:0]  den_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_convert_seq #(.BIN_W(16), .DIGITS(5), .BLANK_LEADING(1)) u_dut (
        .CLK100MHZ(clk), .reset(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .valid(valid_a), .bcd(bcd_a), .overflow(ovf_a), .digit_en(den_a)
    );

    bcd_convert_seq #(.BIN_W(16), .DIGITS(4), .BLANK_LEADING(1)) u_d4 (
        .CLK100MHZ(clk), .reset(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .valid(valid_b), .bcd(bcd_b), .overflow(ovf_b), .digit_en(den_b)
    );

    bcd_convert_seq #(.BIN_W(16), .DIGITS(5), .BLANK_LEADING(0)) u_nb (
        .CLK100MHZ(clk), .reset(rst), .start(start_c), .bin(bin_c),
        .busy(busy_c), .valid(valid_c), .bcd(bcd_c), .overflow(ovf_c), .digit_en(den_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one conversion on u_dut from cycle 0. start is pulsed again in cycle
    // restart_at (0 = never). Observes cycles 1..20.
    task automatic do_conv(input logic [15:0] b, input int restart_at,
                           output int vcyc, output int vcnt, output int busy_err);
        bin_a    = b;
        start_a  = 1'b1;
        vcyc     = -1;
        vcnt     = 0;
        busy_err = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            start_a = (k == restart_at);
            if (busy_a !== ((k >= 1 && k <= 17) ? 1'b1 : 1'b0)) busy_err++;
            if (valid_a === 1'b1) begin
                vcnt++;
                if (vcyc < 0) vcyc = k;
            end
        end
        start_a = 1'b0;
    endtask

    initial begin
        int vcyc, vcnt, berr, n;
        int vc_cyc[3];
        logic [19:0] vc_bcd[3];
        logic [4:0]  vc_den[3];

        rst = 1'b1;
        start_a = 0; start_b = 0; start_c = 0;
        bin_a = '0; bin_b = '0; bin_c = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_bcd",   32'(bcd_a),   32'd0);
        check("rst_ovf",   32'(ovf_a),   32'd0);
        check("rst_den",   32'(den_a),   32'b00001);
        check("rst_den_nb", 32'(den_c),  32'b11111);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: zero
        do_conv(16'd0, 0, vcyc, vcnt, berr);
        check("t1_vcyc", 32'(vcyc), 32'd17);
        check("t1_vcnt", 32'(vcnt), 32'd1);
        check("t1_bcd",  32'(bcd_a), 32'h00000);
        check("t1_den",  32'(den_a), 32'b00001);
        check("t1_ovf",  32'(ovf_a), 32'd0);

        // 2: full-scale
        do_conv(16'd65535, 0, vcyc, vcnt, berr);
        check("t2_vcyc", 32'(vcyc), 32'd17);
        check("t2_busy", 32'(berr), 32'd0);
        check("t2_bcd",  32'(bcd_a), 32'h65535);
        check("t2_den",  32'(den_a), 32'b11111);
        check("t2_ovf",  32'(ovf_a), 32'd0);

        // 3: second start pulse while busy is ignored
        do_conv(16'd206, 5, vcyc, vcnt, berr);
        check("t3_vcyc", 32'(vcyc), 32'd17);
        check("t3_vcnt", 32'(vcnt), 32'd1);
        check("t3_busy", 32'(berr), 32'd0);
        check("t3_bcd",  32'(bcd_a), 32'h00206);
        check("t3_den",  32'(den_a), 32'b00111);

        // 5: reset mid-conversion, then a clean conversion
        bin_a = 16'd999;
        start_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy_a),  32'd0);
        check("t5_valid", 32'(valid_a), 32'd0);
        check("t5_bcd",  32'(bcd_a),   32'd0);
        check("t5_den",  32'(den_a),   32'b00001);
        #1;
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (valid_a === 1'b1) vcnt++;
        end
        check("t5_novalid", 32'(vcnt), 32'd0);
        do_conv(16'd42, 0, vcyc, vcnt, berr);
        check("t5_vcyc", 32'(vcyc), 32'd17);
        check("t5_bcd",  32'(bcd_a), 32'h00042);
        check("t5_den",  32'(den_a), 32'b00011);

        // 4: four-digit instance overflows and saturates
        bin_b = 16'd12345;
        start_b = 1'b1;
        vcyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            if (valid_b === 1'b1 && vcyc < 0) vcyc = k;
        end
        check("t4_vcyc", 32'(vcyc), 32'd17);
        check("t4_ovf",  32'(ovf_b), 32'd1);
        check("t4_bcd",  32'(bcd_b), 32'h9999);
        check("t4_den",  32'(den_b), 32'b1111);

        // 6: start held high, bin changed while conversions are in flight
        bin_c = 16'd1;
        start_c = 1'b1;
        n = 0;
        for (int k = 1; k <= 56; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)  bin_c = 16'd10;
            if (k == 19) bin_c = 16'd100;
            if (valid_c === 1'b1) begin
                if (n < 3) begin
                    vc_cyc[n] = k;
                    vc_bcd[n] = bcd_c;
                    vc_den[n] = den_c;
                end
                n++;
            end
        end
        start_c = 1'b0;
        check("t6_count", 32'(n), 32'd3);
        if (n >= 3) begin
            check("t6_cyc0", 32'(vc_cyc[0]), 32'd17);
            check("t6_cyc1", 32'(vc_cyc[1]), 32'd35);
            check("t6_cyc2", 32'(vc_cyc[2]), 32'd53);
            check("t6_bcd0", 32'(vc_bcd[0]), 32'h00001);
            check("t6_bcd1", 32'(vc_bcd[1]), 32'h00010);
            check("t6_bcd2", 32'(vc_bcd[2]), 32'h00100);
            check("t6_den0", 32'(vc_den[0]), 32'b11111);
            check("t6_den2", 32'(vc_den[2]), 32'b11111);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
